// File: rtl/riscv_run_ctrl.sv
// Run/step/halt sequencer for the single-cycle core: streams the instruction image
// into imem under core reset, then gates the core with core_en and counts cycles/retires.
module riscv_run_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int IMEM_AW    = 8,
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic               clock_i,
    input  logic               rst_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [2:0]         cmd_op_i,
    input  logic [ADDR_W-1:0]  cmd_data_i,
    input  logic               load_valid_i,
    output logic               load_ready_o,
    input  logic [31:0]        load_word_i,
    input  logic               load_last_i,
    output logic               imem_we_o,
    output logic [IMEM_AW-1:0] imem_waddr_o,
    output logic [31:0]        imem_wdata_o,
    output logic               core_rst_o,
    output logic               core_en_o,
    input  logic [ADDR_W-1:0]  core_pc_i,
    input  logic               core_halt_req_i,
    output logic [2:0]         state_o,
    output logic [1:0]         halt_cause_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   retired_cnt_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LOAD = 3'd1, S_RST = 3'd2, S_RUN = 3'd3, S_STEP = 3'd4, S_HALT = 3'd5
    } st_t;

    localparam logic [2:0] OP_LOAD = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3, OP_HALT = 3'd4,
                           OP_SETBP = 3'd5, OP_CLRBP = 3'd6;
    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    st_t                state_q;
    logic               core_rst_q, skip_q, bp_en_q, imem_we_q;
    logic [ADDR_W-1:0]  bp_addr_q;
    logic [IMEM_AW-1:0] ptr_q, imem_waddr_q;
    logic [31:0]        imem_wdata_q;
    logic [RCW-1:0]     rst_cnt_q;
    logic [1:0]         halt_cause_q;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d, retired_cnt_q, retired_cnt_d;
    logic               cmd_acc, load_hs, bp_match;

    assign cmd_ready_o  = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_HALT);
    assign load_ready_o = (state_q == S_LOAD);
    assign cmd_acc      = cmd_valid_i & cmd_ready_o;
    assign load_hs      = load_valid_i & load_ready_o;
    assign bp_match     = bp_en_q & (core_pc_i == bp_addr_q) & ~skip_q;

    always_comb begin
        core_en_o = 1'b0;
        if (state_q == S_RUN)       core_en_o = ~bp_match & ~core_halt_req_i;
        else if (state_q == S_STEP) core_en_o = ~core_halt_req_i;
    end

    // A reload from HALTED pulls the core back into reset in the accept cycle itself.
    assign core_rst_o = core_rst_q | ((state_q == S_HALT) & cmd_acc & (cmd_op_i == OP_LOAD));

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (state_q == S_RST) begin
            cycle_cnt_d   = '0;
            retired_cnt_d = '0;
        end else begin
            if (state_q == S_RUN || state_q == S_STEP || state_q == S_HALT)
                cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (core_en_o)
                retired_cnt_d = retired_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            core_rst_q    <= 1'b1;
            skip_q        <= 1'b0;
            bp_en_q       <= 1'b0;
            bp_addr_q     <= '0;
            imem_we_q     <= 1'b0;
            imem_waddr_q  <= '0;
            imem_wdata_q  <= '0;
            ptr_q         <= '0;
            rst_cnt_q     <= '0;
            halt_cause_q  <= 2'd0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
            imem_we_q     <= 1'b0;
            if (load_hs) begin
                imem_we_q    <= 1'b1;
                imem_waddr_q <= ptr_q;
                imem_wdata_q <= load_word_i;
                ptr_q        <= ptr_q + 1'b1;
            end
            if (cmd_acc && cmd_op_i == OP_SETBP) begin
                bp_en_q   <= 1'b1;
                bp_addr_q <= cmd_data_i;
            end
            if (cmd_acc && cmd_op_i == OP_CLRBP) bp_en_q <= 1'b0;

            case (state_q)
                S_IDLE: if (cmd_acc && cmd_op_i == OP_LOAD) begin
                    state_q <= S_LOAD;
                    ptr_q   <= cmd_data_i[IMEM_AW-1:0];
                end
                S_LOAD: if (load_hs && load_last_i) begin
                    state_q   <= S_RST;
                    rst_cnt_q <= RCW'(RST_CYCLES - 1);
                end
                S_RST: begin
                    if (rst_cnt_q == '0) begin
                        state_q      <= S_HALT;
                        core_rst_q   <= 1'b0;
                        halt_cause_q <= 2'd0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 1'b1;
                    end
                end
                S_HALT: if (cmd_acc) begin
                    case (cmd_op_i)
                        OP_LOAD: begin
                            state_q    <= S_LOAD;
                            core_rst_q <= 1'b1;
                            ptr_q      <= cmd_data_i[IMEM_AW-1:0];
                        end
                        OP_RUN:  begin state_q <= S_RUN;  skip_q <= 1'b1; end
                        OP_STEP: begin state_q <= S_STEP; skip_q <= 1'b1; end
                        default: ;
                    endcase
                end
                S_RUN: begin
                    skip_q <= 1'b0;
                    if (core_halt_req_i) begin
                        state_q <= S_HALT; halt_cause_q <= 2'd2;
                    end else if (bp_match) begin
                        state_q <= S_HALT; halt_cause_q <= 2'd1;
                    end else if (cmd_acc && cmd_op_i == OP_HALT) begin
                        state_q <= S_HALT; halt_cause_q <= 2'd0;
                    end
                end
                S_STEP: begin
                    skip_q       <= 1'b0;
                    state_q      <= S_HALT;
                    halt_cause_q <= core_halt_req_i ? 2'd2 : 2'd3;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o       = state_q;
    assign halt_cause_o  = halt_cause_q;
    assign cycle_cnt_o   = cycle_cnt_q;
    assign retired_cnt_o = retired_cnt_q;
    assign imem_we_o     = imem_we_q;
    assign imem_waddr_o  = imem_waddr_q;
    assign imem_wdata_o  = imem_wdata_q;
endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: load, wrap, run/halt, breakpoint, step, priority, reset.
module tb_riscv_run_ctrl;
    logic        clock = 1'b0, rst = 1'b0;
    logic        cmd_valid = 1'b0, load_valid = 1'b0, load_last = 1'b0, core_halt_req = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_data = '0, load_word = '0, core_pc = '0;
    logic        cmd_ready, load_ready, imem_we, core_rst, core_en;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata, cycle_cnt, retired_cnt;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    int tests = 0, failed = 0;

    riscv_run_ctrl dut (
        .clock_i(clock), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_data_i(cmd_data), .load_valid_i(load_valid),
        .load_ready_o(load_ready), .load_word_i(load_word), .load_last_i(load_last),
        .imem_we_o(imem_we), .imem_waddr_o(imem_waddr), .imem_wdata_o(imem_wdata),
        .core_rst_o(core_rst), .core_en_o(core_en), .core_pc_i(core_pc),
        .core_halt_req_i(core_halt_req), .state_o(state), .halt_cause_o(halt_cause),
        .cycle_cnt_o(cycle_cnt), .retired_cnt_o(retired_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    endtask

    // Streams a one-word image at address 0 and waits out RST_CORE.
    task automatic quick_load();
        send_cmd(3'd1, 32'h0); tick(); cmd_valid = 1'b0;
        load_valid = 1'b1; load_last = 1'b1; load_word = 32'h13; tick();
        load_valid = 1'b0; load_last = 1'b0; tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(); tick();
        tests++; if (state !== 3'd0) begin failed++; $display("FAIL rst_state: got %0d expected 0", state); end
        tests++; if (core_rst !== 1'b1) begin failed++; $display("FAIL rst_core_rst: got %0b expected 1", core_rst); end
        tests++; if (core_en !== 1'b0) begin failed++; $display("FAIL rst_core_en: got %0b expected 0", core_en); end
        tests++; if (imem_we !== 1'b0 || imem_waddr !== 8'h0 || imem_wdata !== 32'h0) begin failed++; $display("FAIL rst_imem: got we=%0b a=%0h d=%0h expected 0/0/0", imem_we, imem_waddr, imem_wdata); end
        tests++; if (halt_cause !== 2'd0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin failed++; $display("FAIL rst_cnt: got hc=%0d cyc=%0d ret=%0d expected 0/0/0", halt_cause, cycle_cnt, retired_cnt); end
        tests++; if (cmd_ready !== 1'b1 || load_ready !== 1'b0) begin failed++; $display("FAIL rst_ready: got cmd=%0b load=%0b expected 1/0", cmd_ready, load_ready); end
        rst = 1'b1;
    endtask

    task automatic test_load();
        send_cmd(3'd1, 32'h10); #1;
        tests++; if (cmd_ready !== 1'b1) begin failed++; $display("FAIL load_cmd_ready: got %0b expected 1", cmd_ready); end
        tick(); cmd_valid = 1'b0;
        tests++; if (state !== 3'd1 || load_ready !== 1'b1 || cmd_ready !== 1'b0 || core_rst !== 1'b1) begin failed++; $display("FAIL load_enter: got st=%0d lr=%0b cr=%0b rst=%0b expected 1/1/0/1", state, load_ready, cmd_ready, core_rst); end
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_word = 32'hA0 + i; load_last = (i == 3); tick();
            tests++; if (imem_we !== 1'b1 || imem_waddr !== 8'(8'h10 + i) || imem_wdata !== 32'hA0 + i) begin failed++; $display("FAIL load_write%0d: got we=%0b a=%0h d=%0h expected 1/%0h/%0h", i, imem_we, imem_waddr, imem_wdata, 8'h10 + i, 32'hA0 + i); end
        end
        load_valid = 1'b0; load_last = 1'b0;
        tests++; if (state !== 3'd2 || core_rst !== 1'b1) begin failed++; $display("FAIL load_rst1: got st=%0d rst=%0b expected 2/1", state, core_rst); end
        tick();
        tests++; if (state !== 3'd2 || imem_we !== 1'b0 || core_en !== 1'b0) begin failed++; $display("FAIL load_rst2: got st=%0d we=%0b en=%0b expected 2/0/0", state, imem_we, core_en); end
        tick();
        tests++; if (state !== 3'd5 || core_rst !== 1'b0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0 || halt_cause !== 2'd0) begin failed++; $display("FAIL load_halted: got st=%0d rst=%0b cyc=%0d ret=%0d hc=%0d expected 5/0/0/0/0", state, core_rst, cycle_cnt, retired_cnt, halt_cause); end
    endtask

    task automatic test_wrap();
        send_cmd(3'd1, 32'hFE); #1;
        tests++; if (core_rst !== 1'b1) begin failed++; $display("FAIL wrap_rst_reassert: got %0b expected 1", core_rst); end
        tick(); cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] exp_a;
            exp_a = 8'hFE + 8'(i);
            load_valid = 1'b1; load_word = 32'hB0 + i; load_last = (i == 2); tick();
            tests++; if (imem_we !== 1'b1 || imem_waddr !== exp_a || imem_wdata !== 32'hB0 + i) begin failed++; $display("FAIL wrap_write%0d: got a=%0h d=%0h expected %0h/%0h", i, imem_waddr, imem_wdata, exp_a, 32'hB0 + i); end
        end
        load_valid = 1'b0; load_last = 1'b0; tick(); tick();
        tests++; if (state !== 3'd5 || retired_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin failed++; $display("FAIL wrap_halted: got st=%0d ret=%0d cyc=%0d expected 5/0/0", state, retired_cnt, cycle_cnt); end
    endtask

    task automatic test_run_halt();
        core_pc = 32'h0; send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0;
        tests++; if (state !== 3'd3) begin failed++; $display("FAIL run_enter: got %0d expected 3", state); end
        for (int i = 0; i < 5; i++) begin
            core_pc = 32'(4 * i); #1;
            tests++; if (core_en !== 1'b1) begin failed++; $display("FAIL run_en%0d: got %0b expected 1", i, core_en); end
            tick();
        end
        core_pc = 32'h14; send_cmd(3'd4, 32'h0); #1;
        tests++; if (core_en !== 1'b1 || cmd_ready !== 1'b1) begin failed++; $display("FAIL halt_accept: got en=%0b rdy=%0b expected 1/1", core_en, cmd_ready); end
        tick(); cmd_valid = 1'b0;
        tests++; if (state !== 3'd5 || halt_cause !== 2'd0 || retired_cnt !== 32'd6 || cycle_cnt !== 32'd7) begin failed++; $display("FAIL halt_done: got st=%0d hc=%0d ret=%0d cyc=%0d expected 5/0/6/7", state, halt_cause, retired_cnt, cycle_cnt); end
        tests++; if (core_en !== 1'b0) begin failed++; $display("FAIL halt_en_off: got %0b expected 0", core_en); end
    endtask

    task automatic test_breakpoint();
        send_cmd(3'd5, 32'h0C); tick();
        core_pc = 32'h0; send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin core_pc = 32'(4 * i); tick(); end
        core_pc = 32'h0C; #1;
        tests++; if (core_en !== 1'b0) begin failed++; $display("FAIL bp_en_block: got %0b expected 0", core_en); end
        tick();
        tests++; if (state !== 3'd5 || halt_cause !== 2'd1 || retired_cnt !== 32'd9) begin failed++; $display("FAIL bp_halt: got st=%0d hc=%0d ret=%0d expected 5/1/9", state, halt_cause, retired_cnt); end
        send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0;
        tests++; if (core_en !== 1'b1) begin failed++; $display("FAIL bp_resume_en: got %0b expected 1", core_en); end
        tick();
        tests++; if (state !== 3'd3) begin failed++; $display("FAIL bp_no_rehalt: got %0d expected 3", state); end
        core_pc = 32'h10; send_cmd(3'd4, 32'h0); tick(); cmd_valid = 1'b0;
        tests++; if (state !== 3'd5 || halt_cause !== 2'd0 || retired_cnt !== 32'd11) begin failed++; $display("FAIL bp_resume_halt: got st=%0d hc=%0d ret=%0d expected 5/0/11", state, halt_cause, retired_cnt); end
    endtask

    task automatic test_step();
        core_pc = 32'h0C; send_cmd(3'd3, 32'h0); tick(); cmd_valid = 1'b0;
        tests++; if (state !== 3'd4 || cmd_ready !== 1'b0 || core_en !== 1'b1) begin failed++; $display("FAIL step_pulse: got st=%0d rdy=%0b en=%0b expected 4/0/1", state, cmd_ready, core_en); end
        tick();
        tests++; if (state !== 3'd5 || halt_cause !== 2'd3 || retired_cnt !== 32'd12 || core_en !== 1'b0) begin failed++; $display("FAIL step_done: got st=%0d hc=%0d ret=%0d en=%0b expected 5/3/12/0", state, halt_cause, retired_cnt, core_en); end
        send_cmd(3'd3, 32'h0); tick(); cmd_valid = 1'b0; core_halt_req = 1'b1; #1;
        tests++; if (core_en !== 1'b0) begin failed++; $display("FAIL step_blocked_en: got %0b expected 0", core_en); end
        tick(); core_halt_req = 1'b0;
        tests++; if (state !== 3'd5 || halt_cause !== 2'd2 || retired_cnt !== 32'd12) begin failed++; $display("FAIL step_blocked: got st=%0d hc=%0d ret=%0d expected 5/2/12", state, halt_cause, retired_cnt); end
    endtask

    task automatic test_simultaneous();
        core_pc = 32'h0; send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0; tick();
        core_pc = 32'h0C; send_cmd(3'd4, 32'h0); #1;
        tests++; if (core_en !== 1'b0) begin failed++; $display("FAIL sim_bp_en: got %0b expected 0", core_en); end
        tick(); cmd_valid = 1'b0;
        tests++; if (state !== 3'd5 || halt_cause !== 2'd1 || retired_cnt !== 32'd13) begin failed++; $display("FAIL sim_bp_cause: got st=%0d hc=%0d ret=%0d expected 5/1/13", state, halt_cause, retired_cnt); end
        core_pc = 32'h20; send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0; tick();
        core_pc = 32'h0C; core_halt_req = 1'b1; send_cmd(3'd4, 32'h0); tick();
        cmd_valid = 1'b0; core_halt_req = 1'b0;
        tests++; if (state !== 3'd5 || halt_cause !== 2'd2 || retired_cnt !== 32'd14) begin failed++; $display("FAIL sim_req_cause: got st=%0d hc=%0d ret=%0d expected 5/2/14", state, halt_cause, retired_cnt); end
    endtask

    task automatic test_reset_mid();
        send_cmd(3'd1, 32'h40); tick(); cmd_valid = 1'b0;
        load_valid = 1'b1; load_word = 32'hC0; tick();
        rst = 1'b0; load_valid = 1'b0; tick();
        tests++; if (state !== 3'd0 || core_rst !== 1'b1 || imem_we !== 1'b0 || imem_waddr !== 8'h0 || imem_wdata !== 32'h0 || load_ready !== 1'b0) begin failed++; $display("FAIL midload_rst: got st=%0d rst=%0b we=%0b a=%0h d=%0h lr=%0b expected 0/1/0/0/0/0", state, core_rst, imem_we, imem_waddr, imem_wdata, load_ready); end
        tests++; if (halt_cause !== 2'd0 || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin failed++; $display("FAIL midload_cnt: got hc=%0d cyc=%0d ret=%0d expected 0/0/0", halt_cause, cycle_cnt, retired_cnt); end
        rst = 1'b1;
        quick_load();
        send_cmd(3'd5, 32'h0C); tick();
        core_pc = 32'h30; send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0; tick();
        rst = 1'b0; tick();
        tests++; if (state !== 3'd0 || core_rst !== 1'b1 || core_en !== 1'b0 || retired_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin failed++; $display("FAIL midrun_rst: got st=%0d rst=%0b en=%0b ret=%0d cyc=%0d expected 0/1/0/0/0", state, core_rst, core_en, retired_cnt, cycle_cnt); end
        rst = 1'b1;
        quick_load();
        core_pc = 32'h30; send_cmd(3'd2, 32'h0); tick(); cmd_valid = 1'b0; tick();
        core_pc = 32'h0C; #1;
        tests++; if (core_en !== 1'b1) begin failed++; $display("FAIL bp_cleared_0c: got %0b expected 1", core_en); end
        tick(); core_pc = 32'h0; #1;
        tests++; if (core_en !== 1'b1) begin failed++; $display("FAIL bp_cleared_00: got %0b expected 1", core_en); end
        tick();
        tests++; if (state !== 3'd3 || retired_cnt !== 32'd3) begin failed++; $display("FAIL bp_cleared_run: got st=%0d ret=%0d expected 3/3", state, retired_cnt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap();
        test_run_halt();
        test_breakpoint();
        test_step();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/riscv_run_ctrl.md
Name: riscv_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle RISC-V core (RISCVunicycle). Loads instruction memory from a streaming loader while holding the core in reset. Then gates the core with a clock-enable under RUN, STEP, HALT and PC-breakpoint control, and keeps cycle/retired-instruction counters. Sits between the bench/debug host and the core, replacing hand-toggled clock and reset sequencing.

Parameters:
ADDR_W, 32, width of core PC and breakpoint address
IMEM_AW, 8, instruction-memory word-address width
CNT_W, 32, width of cycle_cnt and retired_cnt
RST_CYCLES, 2, cycles core_rst is held after a load completes (min 1)

Ports:
clock  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_op  in  3  0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 HALT, 5 SET_BP, 6 CLR_BP, 7 NOP
cmd_data  in  ADDR_W  LOAD: start word address [IMEM_AW-1:0]; SET_BP: breakpoint PC
load_valid  in  1  loader word valid
load_ready  out  1  loader handshake ready
load_word  in  32  instruction word
load_last  in  1  final word of image
imem_we  out  1  instruction-memory write strobe
imem_waddr  out  IMEM_AW  write word address
imem_wdata  out  32  write data
core_rst  out  1  core reset, active-high
core_en  out  1  core clock enable; the core retires one instruction per enabled cycle
core_pc  in  ADDR_W  current core PC
core_halt_req  in  1  core decoded ECALL/EBREAK at core_pc
state  out  3  0 IDLE, 1 LOAD, 2 RST_CORE, 3 RUN, 4 STEP, 5 HALTED
halt_cause  out  2  0 HALT cmd, 1 breakpoint, 2 core_halt_req, 3 step done
cycle_cnt  out  CNT_W  cycles spent in RUN/STEP/HALTED since last core reset
retired_cnt  out  CNT_W  number of core_en=1 cycles since last core reset

Behaviour:
- Reset (rst=0 at an edge): state IDLE, core_rst=1, core_en=0, imem_we=0, imem_waddr=0, imem_wdata=0, halt_cause=0, counters 0, breakpoint disabled, bp_addr=0, skip flag 0. Reset applies mid-operation in any state; an in-flight load is abandoned.
- cmd_ready=1 in IDLE, RUN, HALTED; 0 in LOAD, RST_CORE, STEP. Every accepted command is consumed. A command illegal in the current state is a no-op.
- SET_BP/CLR_BP accepted in IDLE/RUN/HALTED. Effect takes hold next cycle.
- IDLE: LOAD -> LOAD. RUN/STEP/HALT ignored, because the core is not loaded.
- LOAD: core_rst=1, load_ready=1. Each load handshake registers imem_we=1, imem_waddr=ptr, imem_wdata=load_word on the following cycle, then increments ptr. ptr starts at cmd_data[IMEM_AW-1:0] and wraps at 2^IMEM_AW to 0. A handshake with load_last=1 writes its word and moves to RST_CORE.
- RST_CORE: core_rst=1, core_en=0 for exactly RST_CYCLES cycles. Both counters clear. Then HALTED with core_rst=0, halt_cause=0.
- HALTED: LOAD -> LOAD, with core_rst reasserted the same cycle. RUN -> RUN. STEP -> STEP. RUN and STEP set the skip flag.
- bp_match = bp_en & (core_pc == bp_addr) & ~skip.
- core_en is combinational. In RUN: ~bp_match & ~core_halt_req. In STEP: ~core_halt_req. Otherwise 0.
- RUN exit to HALTED, priority core_halt_req > bp_match > HALT cmd, setting halt_cause 2/1/0:
  - core_halt_req or bp_match in a cycle: core_en=0 that cycle; state HALTED next cycle.
  - HALT cmd accepted: the core is enabled in the accept cycle (unless halt_req/bp); HALTED next cycle.
- STEP lasts exactly one cycle. It ignores the breakpoint and always goes to HALTED. halt_cause=3 if the step executed, 2 if it was blocked by core_halt_req.
- The skip flag clears after the first RUN/STEP cycle, so resuming at a breakpoint PC executes that instruction once.
- retired_cnt += 1 on every cycle with core_en=1. cycle_cnt += 1 every cycle in RUN/STEP/HALTED. Both wrap modulo 2^CNT_W.
- Outputs state, halt_cause and the counters are registered. cmd_ready, load_ready and core_en are combinational from state and inputs.

Test Plan:
- Reset then load: LOAD cmd_data=0x10, stream 4 words 0xA0..0xA3, last on 4th -> imem_we pulses at addrs 0x10..0x13 with matching data. RST_CORE holds core_rst=1 for 2 cycles, then HALTED, core_rst=0, counters 0.
- Wrap: LOAD at 0xFE, 3 words -> addrs 0xFE, 0xFF, 0x00.
- RUN then HALT cmd after 5 enabled cycles -> retired_cnt=6 (accept cycle included), state HALTED, halt_cause=0, core_en=0 thereafter.
- SET_BP 0x0C, RUN with PC stepping 0,4,8,0x0C -> core_en=0 at PC 0x0C, halt_cause=1, retired_cnt=3. RUN again -> 0x0C executes, no immediate re-halt.
- STEP from HALTED with core_pc=bp_addr -> exactly one core_en pulse, retired_cnt+1, halt_cause=3. STEP with core_halt_req=1 -> no pulse, halt_cause=2.
- Simultaneous and reset mid-op: HALT cmd in the same cycle as bp_match -> halt_cause=1. rst=0 mid-LOAD and mid-RUN -> all outputs at reset values next cycle, breakpoint cleared.
